// File: rtl/wptr_full_if.sv
// Write-side FIFO pointer bundle: producer handshake, synchronized read
// pointer in, Gray write pointer / address / flags out.
// Optional overflow status signals are present when WPTR_FULL_OVF_STATUS_EN
// is defined.
interface wptr_full_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  winc;
   logic [ADDR_WIDTH:0]   wq2_rptr;
   logic [ADDR_WIDTH:0]   wptr;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  wfull;
   logic                  walmost_full;
   logic [ADDR_WIDTH:0]   wlevel;
`ifdef WPTR_FULL_OVF_STATUS_EN
   logic                  wovf_clr;
   logic                  wovf;
   logic [7:0]            wovf_cnt;

   modport master (
      output winc, wq2_rptr, wovf_clr,
      input  wptr, waddr, wfull, walmost_full, wlevel, wovf, wovf_cnt
   );
   modport slave (
      input  winc, wq2_rptr, wovf_clr,
      output wptr, waddr, wfull, walmost_full, wlevel, wovf, wovf_cnt
   );
`else
   modport master (
      output winc, wq2_rptr,
      input  wptr, waddr, wfull, walmost_full, wlevel
   );
   modport slave (
      input  winc, wq2_rptr,
      output wptr, waddr, wfull, walmost_full, wlevel
   );
`endif
endinterface

// File: rtl/wptr_full.sv
// Async-FIFO write-side pointer and full/almost-full flag generator.
// Binary pointer advances on accepted writes; its Gray form crosses to the
// read domain. Flags are registered and computed against the already
// synchronized read pointer, so they are pessimistic.
// Optional macro WPTR_FULL_OVF_STATUS_EN adds sticky overflow status and a
// saturating dropped-write counter.
module wptr_full #(
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = 12
) (
   input logic          wclk,
   input logic          wrst,
   wptr_full_if.slave   bus
);

   localparam logic [ADDR_WIDTH:0] AFULL_LVL = AFULL_THRESH[ADDR_WIDTH:0];

   logic [ADDR_WIDTH:0] wbin;
   logic [ADDR_WIDTH:0] wbin_next;
   logic [ADDR_WIDTH:0] wgray_next;
   logic [ADDR_WIDTH:0] rbin;
   logic [ADDR_WIDTH:0] level_next;
   logic                accept;
   logic                full_next;
   logic                afull_next;

   assign bus.waddr = wbin[ADDR_WIDTH-1:0];

   // Next pointer, read-pointer decode and next-state flags.
   always_comb begin
      accept     = bus.winc & ~bus.wfull;
      wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, accept};
      wgray_next = wbin_next ^ (wbin_next >> 1);
      rbin       = '0;
      // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
      for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
         rbin[i] = ^(bus.wq2_rptr >> i);
      end
      level_next = wbin_next - rbin;
      full_next  = (wgray_next == {~bus.wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                    bus.wq2_rptr[ADDR_WIDTH-2:0]});
      afull_next = (level_next >= AFULL_LVL);
   end

   // Pointer and flag registers with synchronous reset.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin             <= '0;
         bus.wptr         <= '0;
         bus.wfull        <= 1'b0;
         bus.walmost_full <= 1'b0;
         bus.wlevel       <= '0;
      end else begin
         wbin             <= wbin_next;
         bus.wptr         <= wgray_next;
         bus.wfull        <= full_next;
         bus.walmost_full <= afull_next;
         bus.wlevel       <= level_next;
      end
   end

`ifdef WPTR_FULL_OVF_STATUS_EN
   logic drop;

   assign drop = bus.winc & bus.wfull;

   // Sticky overflow flag and saturating drop counter; a drop in the clear
   // cycle wins and restarts the count at one.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         bus.wovf     <= 1'b0;
         bus.wovf_cnt <= '0;
      end else if (drop) begin
         bus.wovf <= 1'b1;
         if (bus.wovf_clr) begin
            bus.wovf_cnt <= 8'd1;
         end else if (bus.wovf_cnt != 8'hFF) begin
            bus.wovf_cnt <= bus.wovf_cnt + 8'd1;
         end
      end else if (bus.wovf_clr) begin
         bus.wovf     <= 1'b0;
         bus.wovf_cnt <= '0;
      end
   end
`endif

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 4, FIFO address width (depth 2^ADDR_WIDTH), legal range >= 2.
REQ-002 SHALL provide parameter AFULL_THRESH, default 12, fill level at or above which walmost_full asserts, legal range 1..2^ADDR_WIDTH.
REQ-003 SHALL have one clock and a synchronous, active-high reset, sampled only on posedge wclk.
REQ-004 wclk  input  1  write-domain clock.
REQ-005 wrst  input  1  synchronous active-high reset.
REQ-006 winc  input  1  write request from producer.
REQ-007 wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into wclk.
REQ-008 wptr  output  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer.
REQ-009 waddr  output  ADDR_WIDTH  memory write address, low bits of binary write pointer.
REQ-010 wfull  output  1  registered full flag.
REQ-011 walmost_full  output  1  registered almost-full flag.
REQ-012 wlevel  output  ADDR_WIDTH+1  registered write-side fill estimate, 0..2^ADDR_WIDTH.
REQ-013 wovf_clr  input  1  overflow status clear (present only with WPTR_FULL_OVF_STATUS_EN).
REQ-014 wovf  output  1  sticky overflow flag (present only with WPTR_FULL_OVF_STATUS_EN).
REQ-015 wovf_cnt  output  8  dropped-write count (present only with WPTR_FULL_OVF_STATUS_EN).

Function
REQ-016 Write SHALL be accepted in a cycle iff winc=1 and wfull=0; waddr is the write location for that cycle.
REQ-017 Binary pointer wbin SHALL advance by exactly 1 per accepted write, modulo 2^(ADDR_WIDTH+1).
REQ-018 wptr SHALL equal Gray(wbin) = wbin ^ (wbin>>1), updated on the same edge as wbin; at most one wptr bit SHALL change per cycle.
REQ-019 wfull SHALL be registered: next value is 1 iff Gray(wbin_next) equals wq2_rptr with its two MSBs inverted and remaining bits equal.
REQ-020 winc while wfull=1 SHALL be dropped: wbin, wptr, waddr unchanged.
REQ-021 wlevel next SHALL equal (wbin_next - Gray2Bin(wq2_rptr)) modulo 2^(ADDR_WIDTH+1).
REQ-022 walmost_full next SHALL equal (wlevel_next >= AFULL_THRESH).
REQ-023 Flags SHALL be pessimistic: wfull/walmost_full deassert only after reader progress appears on wq2_rptr; no combinational path winc->wfull.
REQ-024 Pointer wrap from 2^(ADDR_WIDTH+1)-1 to 0 SHALL produce wptr=0 with no spurious wfull.
REQ-025 A write accepted on the edge wq2_rptr changes SHALL be evaluated against the new wq2_rptr sample for next-state flags.

Reset
REQ-026 wrst=1 SHALL on the next posedge wclk force wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0, wovf_cnt=0.
REQ-027 wrst SHALL take priority over winc and wovf_clr; a write in a reset cycle SHALL be discarded.
REQ-028 Reset mid-operation SHALL need no drain; first write after release goes to waddr=0.

Configuration
REQ-029 Macro WPTR_FULL_OVF_STATUS_EN defined: wovf_clr/wovf/wovf_cnt exist; dropped write sets wovf (set beats clear same cycle); wovf_cnt increments per dropped write, saturates at 255; wovf_clr=1 zeroes both unless a drop occurs that cycle (then wovf=1, wovf_cnt=1).
REQ-030 Macro undefined: those ports and their logic SHALL be absent; REQ-016..028 unchanged.

Verification (ADDR_WIDTH=4, AFULL_THRESH=12, macro defined)
REQ-031 Reset, wq2_rptr=0, 16 consecutive winc -> wfull=1 on edge of 16th write, wptr=5'b11000, wlevel=16, waddr=0.
REQ-032 Full, winc held 3 cycles -> wptr stays 5'b11000, wovf=1, wovf_cnt=3; then wovf_clr=1 one cycle -> wovf=0, wovf_cnt=0.
REQ-033 Full, wq2_rptr driven to 5'b00001 -> next edge wfull=0, wlevel=15, walmost_full=1.
REQ-034 From reset, 11 writes -> walmost_full=0, wlevel=11; 12th write -> walmost_full=1, wlevel=12.
REQ-035 Reader model tracking wptr, 32 writes -> wptr returns 5'b00000, waddr=0, wfull never asserted.
REQ-036 wlevel=7 with winc=1 and wrst=1 same cycle -> next edge all outputs 0, write discarded.
